// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage bundle between the next-PC generator and its neighbours (btb, icache, decode, commit).
// The master side is the PC generator; the slave side is its environment.
interface fetch_pc_gen_if #(
    parameter int unsigned ADDR = 32
);
    logic [ADDR-1:0] btb_addr;
    logic            target_valid;
    logic [ADDR-1:0] target_addr;
    logic            ic_req_;
    logic [ADDR-1:0] ic_addr;
    logic            ic_ack_;
    logic            fetch_stall_;
    logic            redirect_;
    logic [ADDR-1:0] redirect_addr;
    logic            fetch_valid_;
    logic [ADDR-1:0] fetch_pc;
    logic            fetch_pred_taken;
    logic [ADDR-1:0] fetch_pred_addr;

    modport master (
        output btb_addr, ic_req_, ic_addr, fetch_valid_, fetch_pc, fetch_pred_taken, fetch_pred_addr,
        input  target_valid, target_addr, ic_ack_, fetch_stall_, redirect_, redirect_addr
    );

    modport slave (
        input  btb_addr, ic_req_, ic_addr, fetch_valid_, fetch_pc, fetch_pred_taken, fetch_pred_addr,
        output target_valid, target_addr, ic_ack_, fetch_stall_, redirect_, redirect_addr
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: holds the fetch PC, issues icache requests, picks the next PC from
// the btb prediction or sequential increment, and forwards each transferred fetch to decode.
module fetch_pc_gen #(
    parameter int unsigned     ADDR       = 32,
    parameter logic [ADDR-1:0] RESET_VEC  = '0,
    parameter int unsigned     INST_BYTES = 4
) (
    input logic            clk,
    input logic            reset_,
    fetch_pc_gen_if.master bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR-1:0] ALIGN_MASK = ~(ADDR'(INST_BYTES - 1));

    function automatic logic [ADDR-1:0] align_pc(input logic [ADDR-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    state_t          state;
    logic [ADDR-1:0] pc;
    logic            req_active;
    logic            xfer;
    logic [ADDR-1:0] npc;

    logic            vld_p1;
    logic [ADDR-1:0] fetch_pc_p1;
    logic            pred_taken_p1;
    logic [ADDR-1:0] pred_addr_p1;

    // Request is combinational on decode backpressure so a stall blocks the accept in the same cycle.
    assign req_active = reset_ && (state == S_RUN) && bus.fetch_stall_;
    assign xfer       = req_active && !bus.ic_ack_;
    assign npc        = bus.target_valid ? align_pc(bus.target_addr) : pc + ADDR'(INST_BYTES);

    assign bus.btb_addr         = pc;
    assign bus.ic_addr          = pc;
    assign bus.ic_req_          = !req_active;
    assign bus.fetch_valid_     = !vld_p1;
    assign bus.fetch_pc         = fetch_pc_p1;
    assign bus.fetch_pred_taken = pred_taken_p1;
    assign bus.fetch_pred_addr  = pred_addr_p1;

    // Stage p0 -> p1: PC update and fetch record to decode, one cycle after transfer.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state         <= S_BOOT;
            pc            <= align_pc(RESET_VEC);
            vld_p1        <= 1'b0;
            fetch_pc_p1   <= '0;
            pred_taken_p1 <= 1'b0;
            pred_addr_p1  <= '0;
        end else if (!bus.redirect_) begin
            // A concurrent icache accept is dropped; the redirect target is fetched next.
            state  <= S_RUN;
            pc     <= align_pc(bus.redirect_addr);
            vld_p1 <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    if (!bus.fetch_stall_) begin
                        state <= S_HOLD;
                    end else if (xfer) begin
                        pc            <= npc;
                        vld_p1        <= 1'b1;
                        fetch_pc_p1   <= pc;
                        pred_taken_p1 <= bus.target_valid;
                        pred_addr_p1  <= npc;
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.fetch_stall_) state <= S_RUN;
                end
                default: state <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: stimulus pushes expected fetch records into a scoreboard,
// a negedge monitor pops and compares each new record decode would see.
module tb_fetch_pc_gen;
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] paddr;
    } rec_t;

    logic clk;
    logic reset_;
    int   checks;
    int   errors;
    bit   mon_en;
    rec_t sb[$];

    fetch_pc_gen_if #(.ADDR(32)) bus ();

    fetch_pc_gen #(
        .ADDR      (32),
        .RESET_VEC (32'h0000_0000),
        .INST_BYTES(4)
    ) dut (
        .clk   (clk),
        .reset_(reset_),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack_n, input logic tv, input logic [31:0] ta,
                         input logic stall_n, input logic redir_n, input logic [31:0] raddr);
        bus.ic_ack_       = ack_n;
        bus.target_valid  = tv;
        bus.target_addr   = ta;
        bus.fetch_stall_  = stall_n;
        bus.redirect_     = redir_n;
        bus.redirect_addr = raddr;
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] pc, input logic taken, input logic [31:0] paddr);
        sb.push_back({pc, taken, paddr});
    endtask

    // Monitor: a record is new when fetch_valid_ falls or its contents change while low.
    initial begin
        rec_t cur, last, e;
        bit   last_vld;
        last_vld = 1'b0;
        last     = '0;
        forever begin
            @(negedge clk);
            cur = {bus.fetch_pc, bus.fetch_pred_taken, bus.fetch_pred_addr};
            if (mon_en && bus.fetch_valid_ == 1'b0) begin
                if (!last_vld || cur != last) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch actual_pc=%h required=none", cur.pc);
                    end else begin
                        e = sb.pop_front();
                        chk("fetch_pc", cur.pc, e.pc);
                        chk("fetch_pred_taken", {31'd0, cur.taken}, {31'd0, e.taken});
                        chk("fetch_pred_addr", cur.paddr, e.paddr);
                    end
                end
                last_vld = 1'b1;
                last     = cur;
            end else begin
                last_vld = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        reset_ = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        tick();
        tick();
        chk("rst_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd1);
        chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
        chk("rst_pred_taken", {31'd0, bus.fetch_pred_taken}, 32'd0);
        chk("rst_pred_addr", bus.fetch_pred_addr, 32'h0);
        chk("rst_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
        chk("rst_btb_addr", bus.btb_addr, 32'h0);
        mon_en = 1'b1;

        // Boot idle cycle, then sequential fetch 0, 4, 8.
        reset_ = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("boot_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
        tick();
        chk("seq_ic_req_", {31'd0, bus.ic_req_}, 32'd0);
        chk("seq_ic_addr0", bus.ic_addr, 32'h0);
        expect_rec(32'h0, 1'b0, 32'h4);
        tick();
        chk("seq_ic_addr4", bus.ic_addr, 32'h4);
        expect_rec(32'h4, 1'b0, 32'h8);
        tick();
        chk("seq_ic_addr8", bus.ic_addr, 32'h8);
        expect_rec(32'h8, 1'b0, 32'hc);
        tick();

        // BTB hit with misaligned target.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hdeadbe74);
        tick();
        chk("redir_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd1);
        drive(1'b0, 1'b1, 32'hcafecafe, 1'b1, 1'b1, 32'h0);
        chk("hit_ic_addr", bus.ic_addr, 32'hdeadbe74);
        expect_rec(32'hdeadbe74, 1'b1, 32'hcafecafc);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("hit_next_ic_addr", bus.ic_addr, 32'hcafecafc);
        expect_rec(32'hcafecafc, 1'b0, 32'hcafecb00);
        tick();

        // Icache not ready for 3 cycles at 0x100.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
            chk("nack_ic_req_", {31'd0, bus.ic_req_}, 32'd0);
            chk("nack_ic_addr", bus.ic_addr, 32'h100);
            chk("nack_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("ack_ic_addr", bus.ic_addr, 32'h100);
        expect_rec(32'h100, 1'b0, 32'h104);
        tick();

        // Decode stall after fetch_pc=0x20.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        expect_rec(32'h20, 1'b0, 32'h24);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
            chk("stall_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
            tick();
            chk("stall_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd0);
            chk("stall_fetch_pc", bus.fetch_pc, 32'h20);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("release_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
        tick();
        chk("resume_ic_req_", {31'd0, bus.ic_req_}, 32'd0);
        chk("resume_ic_addr", bus.ic_addr, 32'h24);
        expect_rec(32'h24, 1'b0, 32'h28);
        tick();

        // Redirect in the same cycle as an accepted transfer at 0x40.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000);
        chk("rx_ic_req_", {31'd0, bus.ic_req_}, 32'd0);
        chk("rx_ic_addr", bus.ic_addr, 32'h40);
        tick();
        chk("rx_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("rx_next_ic_addr", bus.ic_addr, 32'h8000);
        expect_rec(32'h8000, 1'b0, 32'h8004);
        tick();
        chk("rx_fetch_pc", bus.fetch_pc, 32'h8000);

        // Wrap from all-ones PC.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hfffffffc);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        expect_rec(32'hfffffffc, 1'b0, 32'h0);
        tick();
        chk("wrap_ic_addr", bus.ic_addr, 32'h0);
        expect_rec(32'h0, 1'b0, 32'h4);
        tick();

        // Reset mid-stream with a redirect pending.
        reset_ = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234);
        tick();
        chk("mrst_fetch_valid_", {31'd0, bus.fetch_valid_}, 32'd1);
        chk("mrst_btb_addr", bus.btb_addr, 32'h0);
        chk("mrst_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
        chk("mrst_fetch_pc", bus.fetch_pc, 32'h0);
        reset_ = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("mrst_boot_ic_req_", {31'd0, bus.ic_req_}, 32'd1);
        tick();
        chk("mrst_run_ic_req_", {31'd0, bus.ic_req_}, 32'd0);
        chk("mrst_run_ic_addr", bus.ic_addr, 32'h0);
        tick();
        tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage next-PC generator, directly upstream of the btb.
- Holds the architectural fetch PC and presents it to the btb as btb_addr.
- Consumes target_valid/target_addr to choose the next PC, issues instruction-cache requests, and forwards fetched PC plus prediction to decode.
- Commit-side redirects (mispredict/exception) override all prediction.

Parameters:
- ADDR, 32, address width.
- RESET_VEC, 32'h0000_0000, first fetch PC after reset.
- INST_BYTES, 4, PC increment; power of two.

Ports:
- clk  in  1  clock.
- reset_  in  1  synchronous active-low reset.
- btb_addr  out  ADDR  current PC to btb lookup; combinational copy of pc register.
- target_valid  in  1  btb hit, predict taken.
- target_addr  in  ADDR  btb predicted target.
- ic_req_  out  1  active-low icache request.
- ic_addr  out  ADDR  icache request address; equals btb_addr.
- ic_ack_  in  1  active-low icache accept. Transfer occurs when ic_req_=0 and ic_ack_=0 in the same cycle.
- fetch_stall_  in  1  active-low decode backpressure.
- redirect_  in  1  active-low PC redirect from commit.
- redirect_addr  in  ADDR  redirect target.
- fetch_valid_  out  1  active-low; fetch_* outputs valid to decode.
- fetch_pc  out  ADDR  PC of transferred fetch.
- fetch_pred_taken  out  1  btb predicted taken for fetch_pc.
- fetch_pred_addr  out  ADDR  predicted next PC (target or sequential).

Behaviour:
- All state is updated on posedge clk. Reset is sampled synchronously.
- Reset (reset_=0):
  - pc <= RESET_VEC, state <= S_BOOT.
  - fetch_valid_=1, fetch_pc=0, fetch_pred_taken=0, fetch_pred_addr=0.
  - ic_req_=1 during reset and during S_BOOT.
- States:
  - S_BOOT: one idle cycle after reset release, then -> S_RUN.
  - S_RUN: ic_req_=0 unless fetch_stall_=0.
  - S_HOLD: entered when fetch_stall_=0 in S_RUN. ic_req_=1; fetch_* outputs frozen. Returns to S_RUN in the cycle after fetch_stall_=1.
- Next-PC on transfer: npc = target_valid ? target_addr : pc + INST_BYTES, computed modulo 2^ADDR so all-ones wraps to 0.
- On transfer (next edge):
  - pc <= npc.
  - fetch_valid_ <= 0, fetch_pc <= pc, fetch_pred_taken <= target_valid, fetch_pred_addr <= npc.
- No transfer in S_RUN (ic_ack_=1): pc unchanged, request held. fetch_valid_ <= 1 only if decode is not stalled; otherwise hold.
- Alignment: the low log2(INST_BYTES) bits of every value loaded into pc (RESET_VEC, target_addr, redirect_addr) are forced to 0.
- Redirect, highest priority except reset; valid in any state including S_BOOT:
  - pc <= redirect_addr, fetch_valid_ <= 1, state <= S_RUN.
  - A transfer in the same cycle as redirect_=0 is discarded: pc still takes redirect_addr and no fetch_valid_ pulse results.
  - ic_req_ is still driven in that cycle; the icache tolerates a dropped accept.
- Fetch latency: a PC is issued combinationally; its fetch_* record appears one cycle after transfer.
- Back-to-back transfers with continuous ack give one fetch per cycle.
- Stall entry while fetch_valid_=0: the record stays valid and unchanged until the stall is released.
- Reset mid-operation: returns to the reset values above regardless of state or any pending redirect.

Test Plan:
- Reset release, ic_ack_=0, no btb hit:
  - S_BOOT idle cycle, then ic_addr = 0, 4, 8 on consecutive cycles.
  - fetch_pc 0, 4, 8 one cycle later; fetch_pred_taken=0.
- BTB hit: at pc=32'hdeadbe74 drive target_valid=1, target_addr=32'hcafecafe.
  - Next ic_addr = 32'hcafecafc (aligned).
  - fetch_pc=deadbe74, fetch_pred_taken=1, fetch_pred_addr=cafecafc.
- Icache not ready: ic_ack_=1 for 3 cycles at pc=0x100.
  - ic_req_ held 0, ic_addr stays 0x100.
  - fetch_valid_=1 for those cycles; fetch resumes at 0x100 on ack.
- Decode stall: fetch_stall_=0 for 2 cycles after fetch_pc=0x20.
  - ic_req_=1 during the stall; fetch_pc held 0x20 with fetch_valid_=0.
  - After release, next ic_addr=0x24.
- Redirect during transfer: redirect_=0, redirect_addr=0x8000 in the same cycle as ack at pc=0x40.
  - No fetch record for 0x40.
  - Next ic_addr=0x8000; fetch_pc=0x8000 one cycle after its transfer.
- Wrap and mid-run reset:
  - pc=32'hfffffffc with no hit gives next ic_addr=0.
  - reset_=0 mid-stream: next cycle fetch_valid_=1 and pc=RESET_VEC.
